led_pwm_controller: RTL
=======================

# led_pwm_controller

Memory-mapped LED output controller on the processor data bus. It generalises the single-register LED port with per-LED blink, a global PWM brightness and a programmable blink period. It decodes a four-word register window on the shared `dbus`, drives `LBITS` board LEDs from registered outputs, and is the drop-in replacement for the plain LED port in the bussed-device system.

## Interface

- `DBITS`, 32: data/address bus width.
- `LBITS`, 10: number of LEDs; must satisfy 1 ≤ LBITS ≤ DBITS.
- `PWM_BITS`, 8: PWM counter width; 1 ≤ PWM_BITS ≤ 16.
- `BLINK_BITS`, 16: blink period register width; ≤ DBITS.
- `LED_BASE`, 32'hF0000000: base byte address of the register window; 16-byte aligned.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `dbus` inout DBITS: shared data bus; written on stores, driven by this block only on its reads.
- `address` in DBITS: bus byte address.
- `wrtEn` in 1: 1 = store cycle, 0 = load cycle.
- `led` out LBITS: LED drive, registered.

## Operation

- Decode: `sel = (address[DBITS-1:4] == LED_BASE[DBITS-1:4])`. `address[3:2]` picks the register, and `address[1:0]` is ignored.
  - Offset 0x0 DATA [LBITS-1:0]: LED enable.
  - Offset 0x4 BLINK [LBITS-1:0]: per-LED blink mask.
  - Offset 0x8 DUTY [PWM_BITS-1:0]: global brightness.
  - Offset 0xC PERIOD [BLINK_BITS-1:0]: blink half-period in PWM frames.
- Write: on a clock edge with `sel && wrtEn`, the addressed register takes the low bits of `dbus`. Upper bus bits are ignored.
- Read: while `sel && !wrtEn`, `dbus` is combinationally driven with the addressed register, zero-extended to DBITS. Otherwise `dbus` is high-Z.
  - Reads have no side effects.
- PWM counter `pcnt` (PWM_BITS):
  - Free-running and increments every cycle.
  - Wraps all-ones → 0. The wrap cycle is `frame_tick`.
  - `pwm_on = (DUTY == all-ones) || (pcnt < DUTY)`, so DUTY=0 means always off and all-ones means always on (100%).
- Blink counter `bcnt` (BLINK_BITS) and phase bit `bphase`:
  - On `frame_tick` with PERIOD ≠ 0: if `bcnt == PERIOD-1`, then `bcnt` ← 0 and `bphase` toggles; else `bcnt` increments.
  - PERIOD == 0: `bcnt` ← 0 and `bphase` ← 1 every cycle (blink disabled, LEDs steady).
  - A write to PERIOD clears `bcnt` and sets `bphase` ← 1 on the same edge.
- Output register: `led[i]` ← `DATA[i] & pwm_on & (~BLINK[i] | bphase)`.

## Timing

- Reset values: DATA=0, BLINK=0, DUTY=all-ones, PERIOD=0, `pcnt`=0, `bcnt`=0, `bphase`=1, `led`=0. `dbus` is high-Z unless a read is selected.
- `reset` has priority over a coincident write.
- Reset mid-frame restarts PWM and blink from zero on the next edge.
- Write-to-LED latency is one cycle: a write at edge N updates the register at N, and `led` reflects it at edge N+1.
- Read data is valid in the same cycle as the address (combinational). A read in the cycle after a write returns the new value.
- A DUTY change takes effect on the next comparison; there is no frame-boundary shadowing.
- A blink toggle occurs every PERIOD × 2^PWM_BITS cycles, giving a full blink cycle of 2·PERIOD·2^PWM_BITS cycles.
- When a write and `frame_tick` coincide on PERIOD, the write wins (`bcnt`←0, `bphase`←1).

## Test plan

- Reset and default: hold `reset` 2 cycles, then write DATA=0x3FF.
  - `led` is 0 during reset.
  - `led` is 0x3FF one cycle after the write edge and stays constant (DUTY reset all-ones).
  - Read of 0x0 returns 0x000003FF.
  - `dbus` is Z when unselected.
- PWM duty (PWM_BITS=8): DATA=0x001, DUTY=0x40.
  - `led[0]` is high exactly 64 of every 256 cycles, aligned to `pcnt` 0..63.
  - DUTY=0 gives constant 0.
- Blink: DATA=0x003, BLINK=0x002, PERIOD=2, DUTY=all-ones.
  - `led[0]` stays steady 1.
  - `led[1]` toggles every 512 cycles, starting high after the PERIOD write.
- PERIOD=0 mid-blink while `bphase`=0: the masked LED returns high on the next cycle and stays high.
- Address decode: write to LED_BASE+0x10 and LED_BASE−4.
  - No register changes.
  - `dbus` is never driven.
  - Write to LED_BASE+0x9 (byte offset) updates DUTY.
- Reset mid-operation with a blink running: assert `reset` when `bphase`=0.
  - All registers return to reset values.
  - `led`=0 the next cycle.

Source files
------------

// File: rtl/led_pwm_controller.sv
// Memory-mapped LED controller: four-register window on the shared data bus
// giving per-LED enable, per-LED blink mask, global PWM brightness and a
// programmable blink half-period counted in PWM frames.
module led_pwm_controller #(
    parameter int unsigned      DBITS      = 32,
    parameter int unsigned      LBITS      = 10,
    parameter int unsigned      PWM_BITS   = 8,
    parameter int unsigned      BLINK_BITS = 16,
    parameter logic [DBITS-1:0] LED_BASE   = DBITS'(32'hF000_0000)
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [DBITS-1:0] dbus,
    input  logic [DBITS-1:0] address,
    input  logic             wrtEn,
    output logic [LBITS-1:0] led
);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_BLINK  = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;
    localparam logic [1:0] REG_PERIOD = 2'd3;

    logic [LBITS-1:0]      data_q,   data_d;
    logic [LBITS-1:0]      blink_q,  blink_d;
    logic [PWM_BITS-1:0]   duty_q,   duty_d;
    logic [BLINK_BITS-1:0] period_q, period_d;
    logic [PWM_BITS-1:0]   pcnt_q,   pcnt_d;
    logic [BLINK_BITS-1:0] bcnt_q,   bcnt_d;
    logic                  bphase_q, bphase_d;
    logic [LBITS-1:0]      led_q,    led_d;

    logic             sel_c;
    logic             wr_c;
    logic             rd_c;
    logic [1:0]       reg_idx_c;
    logic [DBITS-1:0] rdata_c;
    logic             frame_tick_c;
    logic             pwm_on_c;
    logic             unused_c;

    // Byte-lane bits and bus bits above the register widths carry no meaning here
    assign unused_c = ^{address[1:0], dbus};

    // Window decode on the upper address bits; word offset selects the register
    assign sel_c     = (address[DBITS-1:4] == LED_BASE[DBITS-1:4]);
    assign wr_c      = sel_c & wrtEn;
    assign rd_c      = sel_c & ~wrtEn;
    assign reg_idx_c = address[3:2];

    assign frame_tick_c = (pcnt_q == '1);
    assign pwm_on_c     = (duty_q == '1) || (pcnt_q < duty_q);

    // Read-back mux, zero-extended to the bus width
    always_comb begin
        rdata_c = '0;
        case (reg_idx_c)
            REG_DATA:   rdata_c = DBITS'(data_q);
            REG_BLINK:  rdata_c = DBITS'(blink_q);
            REG_DUTY:   rdata_c = DBITS'(duty_q);
            REG_PERIOD: rdata_c = DBITS'(period_q);
            default:    rdata_c = '0;
        endcase
    end

    // Drive the shared bus only while this window is being loaded
    assign dbus = rd_c ? rdata_c : {DBITS{1'bz}};

    assign led = led_q;

    // Next-state: register writes, PWM/blink counters and LED output
    always_comb begin
        data_d   = data_q;
        blink_d  = blink_q;
        duty_d   = duty_q;
        period_d = period_q;
        pcnt_d   = pcnt_q + PWM_BITS'(1);
        bcnt_d   = bcnt_q;
        bphase_d = bphase_q;

        if (wr_c) begin
            case (reg_idx_c)
                REG_DATA:   data_d   = dbus[LBITS-1:0];
                REG_BLINK:  blink_d  = dbus[LBITS-1:0];
                REG_DUTY:   duty_d   = dbus[PWM_BITS-1:0];
                REG_PERIOD: period_d = dbus[BLINK_BITS-1:0];
                default:    ;
            endcase
        end

        // A PERIOD write restarts the blink in the lit phase, overriding a frame tick
        if (wr_c && (reg_idx_c == REG_PERIOD)) begin
            bcnt_d   = '0;
            bphase_d = 1'b1;
        end else if (period_q == '0) begin
            bcnt_d   = '0;
            bphase_d = 1'b1;
        end else if (frame_tick_c) begin
            if (bcnt_q == (period_q - BLINK_BITS'(1))) begin
                bcnt_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                bcnt_d = bcnt_q + BLINK_BITS'(1);
            end
        end

        led_d = data_q & {LBITS{pwm_on_c}} & (~blink_q | {LBITS{bphase_q}});
    end

    // State registers with synchronous reset taking priority over writes
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            blink_q  <= '0;
            duty_q   <= '1;
            period_q <= '0;
            pcnt_q   <= '0;
            bcnt_q   <= '0;
            bphase_q <= 1'b1;
            led_q    <= '0;
        end else begin
            data_q   <= data_d;
            blink_q  <= blink_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
            bcnt_q   <= bcnt_d;
            bphase_q <= bphase_d;
            led_q    <= led_d;
        end
    end

endmodule
